spi_port_expander: RTL and testbench

//  Parametrised SPI-slave GPIO expander. Successor to the single-byte expander: NUM_PORTS

---
 rtl/spi_port_expander_pkg.sv | 17 +
 rtl/spi_port_expander_if.sv | 11 +
 rtl/spi_port_expander_byte_slave.sv | 90 +++++++++
 rtl/spi_port_expander.sv | 148 ++++++++++++++
 tb/tb_spi_port_expander.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_port_expander_pkg.sv
// Shared codes for the SPI GPIO expander: register selects, command layout, FSM states.
package spi_port_expander_pkg;

    localparam int ADDR_W     = 4;
    localparam int CMD_RW_BIT = 7;

    localparam logic [1:0] SEL_OUT   = 2'd0;
    localparam logic [1:0] SEL_DIR   = 2'd1;
    localparam logic [1:0] SEL_IN    = 2'd2;
    localparam logic [1:0] SEL_IMASK = 2'd3;

    typedef enum logic {
        ST_CMD,
        ST_DATA
    } fsm_state_t;

endpackage

// File: rtl/spi_port_expander_if.sv
// SPI pin bundle between the chip io pins (master side) and the expander (slave side).
interface spi_port_expander_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output ss, output sclk, output mosi, input miso, input miso_oe);
    modport slave  (input ss, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_port_expander_byte_slave.sv
// Oversampled SPI mode-0 byte slave: pin synchronisers, edge detect, rx/tx shifters.
module spi_byte_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       miso,
    output logic       miso_oe,
    output logic       frame_active
);

    logic [SYNC_STAGES-1:0][2:0] pin_sync;
    logic       ss_s, sclk_s, mosi_s;
    logic       ss_d, sclk_d, frame_q;
    logic       ss_fall, sclk_rise, sclk_fall;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh;

    // Synchronise {ss, sclk, mosi} together so their relative timing is preserved
    always_ff @(posedge clk) begin
        if (rst) pin_sync <= '0;
        else     pin_sync <= {pin_sync[SYNC_STAGES-2:0], {ss, sclk, mosi}};
    end

    assign {ss_s, sclk_s, mosi_s} = pin_sync[SYNC_STAGES-1];

    // A frame opens only on a seen ss fall, so a reset with ss held low stays idle
    assign ss_fall      = ss_d & ~ss_s;
    assign frame_active = frame_q & ~ss_s;
    assign sclk_rise    = frame_active & sclk_s & ~sclk_d;
    assign sclk_fall    = frame_active & ~sclk_s & sclk_d;
    assign miso_oe      = frame_q;

    // Edge history and frame flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_d    <= 1'b0;
            sclk_d  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            ss_d   <= ss_s;
            sclk_d <= sclk_s;
            if (ss_s)         frame_q <= 1'b0;
            else if (ss_fall) frame_q <= 1'b1;
        end
    end

    // Receive shifter; a partial byte is dropped when the frame closes
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_sh      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (!frame_active) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                rx_sh   <= {rx_sh[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {rx_sh[6:0], mosi_s};
                end
            end
        end
    end

    // Transmit shifter; each falling edge presents the next bit, MSB first
    always_ff @(posedge clk) begin
        if (rst || !frame_active) begin
            tx_sh <= '0;
            miso  <= 1'b0;
        end else if (tx_load) begin
            tx_sh <= tx_byte;
        end else if (sclk_fall) begin
            miso  <= tx_sh[7];
            tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_port_expander.sv
// SPI-slave GPIO expander: command/address FSM, per-port register file, change interrupt.
module spi_port_expander
    import spi_port_expander_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    spi_port_expander_if.slave          spi,
    input  logic [NUM_PORTS*PORT_W-1:0] gpio_in,
    output logic [NUM_PORTS*PORT_W-1:0] gpio_out,
    output logic [NUM_PORTS*PORT_W-1:0] gpio_oe,
    output logic                        irq
);

    localparam int GW = NUM_PORTS * PORT_W;

    typedef logic [NUM_PORTS-1:0][PORT_W-1:0] port_vec_t;

    port_vec_t out_q, dir_q, imask_q, pend_q;
    port_vec_t in_s, in_d, clr_mask;
    logic [SYNC_STAGES-1:0][GW-1:0] gin_sync;

    fsm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
    logic              rw_q, rw_d, rd_is_read;
    logic              wr_en, tx_load, byte_valid, frame_active;
    logic [7:0]        rx_byte, rd_data;

    spi_byte_slave #(.SYNC_STAGES(SYNC_STAGES)) u_byte (
        .clk          (clk),
        .rst          (rst),
        .ss           (spi.ss),
        .sclk         (spi.sclk),
        .mosi         (spi.mosi),
        .tx_load      (tx_load),
        .tx_byte      (rd_data),
        .byte_valid   (byte_valid),
        .rx_byte      (rx_byte),
        .miso         (spi.miso),
        .miso_oe      (spi.miso_oe),
        .frame_active (frame_active)
    );

    // FSM state, burst address and direction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CMD;
            addr_q  <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
        end
    end

    // Byte decode: CMD latches rw/addr, each DATA byte writes addr and advances it.
    // The read value for the next byte's slot is loaded on every completed byte.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wr_en      = 1'b0;
        tx_load    = 1'b0;
        rd_addr    = addr_q + 4'd1;
        rd_is_read = rw_q;
        if (!frame_active) begin
            state_d = ST_CMD;
        end else if (byte_valid) begin
            tx_load = 1'b1;
            case (state_q)
                ST_CMD: begin
                    state_d    = ST_DATA;
                    rw_d       = rx_byte[CMD_RW_BIT];
                    addr_d     = rx_byte[ADDR_W-1:0];
                    rd_addr    = rx_byte[ADDR_W-1:0];
                    rd_is_read = rx_byte[CMD_RW_BIT];
                end
                ST_DATA: begin
                    wr_en  = ~rw_q;
                    addr_d = addr_q + 4'd1;
                end
                default: state_d = ST_CMD;
            endcase
        end
    end

    // Read mux; a read-frame load of IN also clears that port's pending bits
    always_comb begin
        rd_data  = '0;
        clr_mask = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_addr[3:2] == 2'(p)) begin
                case (rd_addr[1:0])
                    SEL_OUT:   rd_data[PORT_W-1:0] = out_q[p];
                    SEL_DIR:   rd_data[PORT_W-1:0] = dir_q[p];
                    SEL_IN:    rd_data[PORT_W-1:0] = in_s[p];
                    SEL_IMASK: rd_data[PORT_W-1:0] = imask_q[p];
                    default:   rd_data = '0;
                endcase
                if (tx_load && rd_is_read && rd_addr[1:0] == SEL_IN)
                    clr_mask[p] = '1;
            end
        end
    end

    // Register file writes; absent ports and the IN slot ignore writes
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            imask_q <= '0;
        end else if (wr_en) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (addr_q[3:2] == 2'(p)) begin
                    case (addr_q[1:0])
                        SEL_OUT:   out_q[p]   <= rx_byte[PORT_W-1:0];
                        SEL_DIR:   dir_q[p]   <= rx_byte[PORT_W-1:0];
                        SEL_IMASK: imask_q[p] <= rx_byte[PORT_W-1:0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Pad input sync and change detect; a new change wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            gin_sync <= '0;
            in_d     <= '0;
            pend_q   <= '0;
        end else begin
            gin_sync <= {gin_sync[SYNC_STAGES-2:0], gpio_in};
            in_d     <= in_s;
            pend_q   <= (pend_q & ~clr_mask) | (in_s ^ in_d);
        end
    end

    assign in_s     = gin_sync[SYNC_STAGES-1];
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(pend_q & imask_q);

endmodule

// File: tb/tb_spi_port_expander.sv
// Randomised self-checking bench for spi_port_expander against a register-map model.
`timescale 1ns/1ps
module tb_spi_port_expander;

    localparam int NP   = 2;
    localparam int PW   = 8;
    localparam int SYNC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*PW-1:0] gpio_in, gpio_out, gpio_oe;
    logic            irq;

    spi_port_expander_if spi();

    spi_port_expander #(.NUM_PORTS(NP), .PORT_W(PW), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (spi.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] data_q[$];
    logic       toggle_at_cmd;
    int         rst_after_bits;

    // Register-map model
    logic [7:0] out_m[4], dir_m[4], imask_m[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 4; p++) begin
            out_m[p] = 8'h00; dir_m[p] = 8'h00; imask_m[p] = 8'h00;
        end
    endfunction

    function automatic logic [7:0] model_rd(input logic [3:0] a);
        int p = int'(a[3:2]);
        if (p >= NP) return 8'h00;
        case (a[1:0])
            2'd0:    return out_m[p];
            2'd1:    return dir_m[p];
            2'd2:    return gpio_in[p*PW +: PW];
            default: return imask_m[p];
        endcase
    endfunction

    function automatic void model_wr(input logic [3:0] a, input logic [7:0] d);
        int p = int'(a[3:2]);
        if (p < NP) begin
            case (a[1:0])
                2'd0:    out_m[p] = d;
                2'd1:    dir_m[p] = d;
                2'd3:    imask_m[p] = d;
                default: ;
            endcase
        end
    endfunction

    function automatic logic [NP*PW-1:0] model_vec(input bit want_dir);
        logic [NP*PW-1:0] v;
        for (int p = 0; p < NP; p++) v[p*PW +: PW] = want_dir ? dir_m[p] : out_m[p];
        return v;
    endfunction

    // Drives one ss-low frame from tx_q; the last byte may be cut short to last_bits
    task automatic spi_frame(input int last_bits);
        int         nbits;
        logic [7:0] r;
        nbits = 0;
        rx_q.delete();
        spi.ss = 1'b0;
        ticks(4);
        chk("miso_oe_active", 32'(spi.miso_oe), 32'd1);
        for (int b = 0; b < tx_q.size(); b++) begin
            int nb;
            nb = (b == tx_q.size() - 1) ? last_bits : 8;
            r  = '0;
            for (int i = 7; i >= 8 - nb; i--) begin
                spi.mosi = tx_q[b][i];
                ticks(4);
                r[i] = spi.miso;
                spi.sclk = 1'b1;
                if (toggle_at_cmd && b == 0 && i == 0) begin
                    ticks(1);
                    gpio_in[0] = ~gpio_in[0];
                    ticks(3);
                end else begin
                    ticks(4);
                end
                spi.sclk = 1'b0;
                nbits++;
                if (nbits == rst_after_bits) begin
                    rst = 1'b1;
                    ticks(2);
                    rst = 1'b0;
                end
            end
            if (nb == 8) rx_q.push_back(r);
        end
        ticks(4);
        spi.ss   = 1'b1;
        spi.mosi = 1'b0;
        ticks(SYNC + 4);
        chk("miso_oe_idle", 32'(spi.miso_oe), 32'd0);
        chk("miso_idle", 32'(spi.miso), 32'd0);
    endtask

    // Full transaction: cmd + n data bytes (data_q for writes), checked against the model
    task automatic xact(input logic rw, input logic [3:0] a, input int n, input string tag);
        logic [3:0] ad;
        logic [7:0] exp_q[$];
        ad = a;
        tx_q.delete();
        tx_q.push_back({rw, 3'b000, a});
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(rw ? 8'h00 : data_q[i]);
            exp_q.push_back(model_rd(ad));
            if (!rw) model_wr(ad, data_q[i]);
            ad = ad + 4'd1;
        end
        spi_frame(8);
        for (int i = 0; i < n; i++)
            chk({tag, "_miso"}, 32'(rx_q[i+1]), 32'(exp_q[i]));
        chk({tag, "_out"}, 32'(gpio_out), 32'(model_vec(1'b0)));
        chk({tag, "_oe"},  32'(gpio_oe),  32'(model_vec(1'b1)));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; spi.ss = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
        gpio_in = '0; toggle_at_cmd = 1'b0; rst_after_bits = -1;
        model_reset();
        ticks(4);
        rst = 1'b0;
        ticks(4);
        chk("rst_out", 32'(gpio_out), 32'd0);
        chk("rst_oe", 32'(gpio_oe), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_miso", 32'(spi.miso), 32'd0);
        chk("rst_miso_oe", 32'(spi.miso_oe), 32'd0);

        // Basic writes of DIR0 then OUT0
        data_q = {8'hFF}; xact(1'b0, 4'h1, 1, "t1_dir");
        data_q = {8'hA5}; xact(1'b0, 4'h0, 1, "t1_out");
        chk("t1_oe_const", 32'(gpio_oe), 32'h00FF);
        chk("t1_out_const", 32'(gpio_out), 32'h00A5);

        // Reads of IN1 and a 3-byte burst from OUT0
        gpio_in = 16'h3C5A;
        ticks(SYNC + 4);
        xact(1'b1, 4'h6, 1, "t2_in1");
        chk("t2_in1_const", 32'(rx_q[1]), 32'h3C);
        xact(1'b1, 4'h0, 3, "t2_burst");
        chk("t2_b0", 32'(rx_q[1]), 32'hA5);
        chk("t2_b1", 32'(rx_q[2]), 32'hFF);
        chk("t2_b2", 32'(rx_q[3]), 32'h5A);

        // Burst write through an absent port, wrapping to OUT0
        data_q = {8'h11, 8'h22}; xact(1'b0, 4'hF, 2, "t3_wrap");
        chk("t3_out0", 32'(gpio_out[7:0]), 32'h22);

        // Aborted data byte leaves registers alone; next frame decodes a fresh cmd
        tx_q = {8'h00, 8'h77};
        spi_frame(5);
        chk("t5_out", 32'(gpio_out), 32'(model_vec(1'b0)));
        xact(1'b1, 4'h0, 1, "t5_read");

        // Random transactions
        for (int k = 0; k < 24; k++) begin
            logic       rw;
            logic [3:0] a;
            int         n;
            rw = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            n  = $urandom_range(1, 4);
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
            gpio_in = 16'($urandom);
            ticks(SYNC + 4);
            xact(rw, a, n, "rnd");
        end

        // Reset in the middle of a burst write; the rest of that frame is ignored
        tx_q = {8'h00, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
        rst_after_bits = 13;
        spi_frame(8);
        rst_after_bits = -1;
        model_reset();
        chk("t6_out", 32'(gpio_out), 32'd0);
        chk("t6_oe", 32'(gpio_oe), 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);
        data_q = {8'h3C, 8'hC3}; xact(1'b0, 4'h0, 2, "t6_after");
        chk("t6_out_const", 32'(gpio_out[7:0]), 32'h3C);
        chk("t6_oe_const", 32'(gpio_oe[7:0]), 32'hC3);

        // Interrupt: set by a pin change, cleared by reading IN, set beats clear
        gpio_in = 16'h1200;
        ticks(SYNC + 4);
        xact(1'b1, 4'h2, 1, "t4_clr");
        data_q = {8'h01}; xact(1'b0, 4'h3, 1, "t4_imask");
        chk("t4_irq_idle", 32'(irq), 32'd0);
        gpio_in[0] = 1'b1;
        ticks(SYNC + 2);
        chk("t4_irq_set", 32'(irq), 32'd1);
        xact(1'b1, 4'h2, 1, "t4_read");
        chk("t4_irq_clr", 32'(irq), 32'd0);
        toggle_at_cmd = 1'b1;
        tx_q = {8'h82, 8'h00};
        spi_frame(8);
        toggle_at_cmd = 1'b0;
        chk("t4_set_wins", 32'(irq), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
